rvv_xrf_wb_arbiter: RTL



---
 rtl/rvv_xrf_wb_arbiter_pkg.sv | 13 +
 rtl/rvv_multi_push_fifo.sv | 69 ++++++
 rtl/rvv_xrf_wb_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/rvv_xrf_wb_arbiter_pkg.sv
// Shared types for the scalar-writeback path from the vector backend to the scalar regfile.
package rvv_xrf_wb_arbiter_pkg;

  localparam int unsigned NUM_RT_UOP = 4;
  localparam int unsigned XREG_AW    = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [XREG_AW-1:0] rt_index;
    logic [XLEN-1:0]    rt_data;
  } RT2XRF_t;

endpackage

// File: rtl/rvv_multi_push_fifo.sv
// In-order circular queue: up to NUM_PUSH compacted entries written per cycle, one popped per cycle.
module rvv_multi_push_fifo #(
  parameter int unsigned NUM_PUSH = 4,
  parameter int unsigned DEPTH    = 8,
  parameter type         entry_t  = logic [7:0],
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned NW = $clog2(NUM_PUSH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [NW-1:0] push_cnt_i,
  input  entry_t        push_data_i [NUM_PUSH],
  input  logic          pop_i,
  output entry_t        head_o,
  output logic          head_valid_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_empty;
  entry_t        r_mem [DEPTH];
  logic [CW-1:0] w_count_next;

  // Pointer increment modulo DEPTH; off never exceeds DEPTH so one subtraction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
    return sum[PW-1:0];
  endfunction

  assign w_count_next = r_count + CW'(push_cnt_i) - CW'(pop_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= wrap_add(r_wptr, 32'(push_cnt_i));
      r_rptr  <= wrap_add(r_rptr, 32'(pop_i));
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage carries no reset; only slots below count are ever observed.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PUSH; i++) begin
      if (NW'(i) < push_cnt_i) r_mem[wrap_add(r_wptr, i)] <= push_data_i[i];
    end
  end

  assign head_o       = r_mem[r_rptr];
  assign head_valid_o = r_valid;
  assign empty_o      = r_empty;
  assign count_o      = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (!rstn) r_count <= CW'(DEPTH));

endmodule

// File: rtl/rvv_xrf_wb_arbiter.sv
// Funnels the multi-lane scalar-writeback retire port into the single async_rd port, in lane then cycle order.
module rvv_xrf_wb_arbiter
  import rvv_xrf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_RT_UOP,
  parameter int unsigned DEPTH     = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned NW = $clog2(NUM_PORTS + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] rt_xrf_valid_i,
  input  RT2XRF_t              rt_xrf_i [NUM_PORTS],
  output logic [NUM_PORTS-1:0] rt_xrf_ready_o,
  output logic                 async_rd_valid_o,
  output logic [XREG_AW-1:0]   async_rd_addr_o,
  output logic [XLEN-1:0]      async_rd_data_o,
  input  logic                 async_rd_ready_i,
  output logic                 wb_idle_o,
  output logic [CW-1:0]        wb_count_o
);

  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_free;
  logic [NUM_PORTS-1:0] w_ready;
  logic [NUM_PORTS-1:0] w_keep;
  logic [NW-1:0]        w_pos [NUM_PORTS];
  logic [NW-1:0]        w_push_cnt;
  RT2XRF_t              w_push_data [NUM_PORTS];
  RT2XRF_t              w_head;
  logic                 w_pop;

  // Prefix-shaped ready from registered occupancy; x0 writes are accepted but not enqueued.
  always_comb begin
    w_free     = CW'(DEPTH) - w_count;
    w_ready    = '0;
    w_keep     = '0;
    w_push_cnt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_ready[i] = (w_free >= CW'(i + 1));
      w_keep[i]  = rt_xrf_valid_i[i] & w_ready[i] & (rt_xrf_i[i].rt_index != '0);
      w_pos[i]   = w_push_cnt;
      w_push_cnt = w_push_cnt + NW'(w_keep[i]);
    end
  end

  // Compact kept lanes into push slots 0..npush-1, oldest lane first.
  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) w_push_data[k] = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_keep[i] && (w_pos[i] == NW'(k))) w_push_data[k] = rt_xrf_i[i];
      end
    end
  end

  assign w_pop = async_rd_valid_o & async_rd_ready_i;

  rvv_multi_push_fifo #(
    .NUM_PUSH (NUM_PORTS),
    .DEPTH    (DEPTH),
    .entry_t  (RT2XRF_t)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .push_cnt_i   (w_push_cnt),
    .push_data_i  (w_push_data),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .head_valid_o (async_rd_valid_o),
    .empty_o      (wb_idle_o),
    .count_o      (w_count)
  );

  assign rt_xrf_ready_o  = w_ready;
  assign async_rd_addr_o = w_head.rt_index;
  assign async_rd_data_o = w_head.rt_data;
  assign wb_count_o      = w_count;

  a_no_push_invalid: assert property (@(posedge clk) disable iff (!rstn)
    (w_keep & ~rt_xrf_valid_i) == '0);

  a_head_hold: assert property (@(posedge clk) disable iff (!rstn)
    (async_rd_valid_o && !async_rd_ready_i) |=>
      ($stable(async_rd_addr_o) && $stable(async_rd_data_o)));

endmodule
